// File: rtl/div_sequencer.sv
// Request/response front end for the 32-bit iterative divider: strips operand signs,
// runs the divider unsigned, restores the sign and returns a tagged response.
module div_sequencer #(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 96
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic             req_signed,
    input  logic             req_rem,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      div_a,
    output logic [31:0]      div_b,
    output logic             div_go,
    output logic             div_divs,
    output logic             div_remainder,
    input  logic [31:0]      div_c,
    input  logic             div_available,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_zero,
    output logic             rsp_negative,
    output logic             rsp_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        FIX   = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic             sa_q, sb_q, rem_q, err_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      raw_q;
    logic [CNT_W-1:0] cnt_q;

    logic accept, b_zero, sa_in, sb_in, timeout_hit;

    // Two's-complement negate when neg is set; 0x80000000 wraps onto itself.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        logic signed [31:0] sv;
        logic signed [31:0] nv;
        sv = $signed(v);
        nv = -sv;
        return neg ? $unsigned(nv) : v;
    endfunction

    function automatic logic [31:0] sign_fix(input logic [31:0] raw, input logic rem,
                                             input logic sa, input logic sb);
        return rem ? cond_neg(raw, sa) : cond_neg(raw, sa ^ sb);
    endfunction

    assign req_ready     = (state == IDLE);
    assign accept        = req_valid && req_ready;
    assign b_zero        = (req_b == 32'd0);
    assign sa_in         = req_signed & req_a[31];
    assign sb_in         = req_signed & req_b[31];
    assign timeout_hit   = (cnt_q == CNT_W'(TIMEOUT - 1));

    assign div_go        = (state == ISSUE);
    assign div_divs      = 1'b0;
    assign div_remainder = rem_q;
    assign rsp_zero      = (rsp_data == 32'd0);
    assign rsp_negative  = rsp_data[31];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = b_zero ? FIX : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (div_available || timeout_hit) state_nxt = FIX;
            FIX:     state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and visible outputs: cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_a     <= '0;
            div_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
            rsp_err   <= 1'b0;
            rem_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    div_a <= cond_neg(req_a, sa_in);
                    div_b <= cond_neg(req_b, sb_in);
                    rem_q <= req_rem;
                    err_q <= b_zero;
                end
                ISSUE: cnt_q <= '0;
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!div_available && timeout_hit) err_q <= 1'b1;
                end
                FIX: begin
                    rsp_data  <= err_q ? raw_q : sign_fix(raw_q, rem_q, sa_q, sb_q);
                    rsp_tag   <= tag_q;
                    rsp_err   <= err_q;
                    rsp_valid <= 1'b1;
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    // Operand bookkeeping: only meaningful while a request is in flight.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (accept) begin
                sa_q  <= sa_in;
                sb_q  <= sb_in;
                tag_q <= req_tag;
                raw_q <= req_rem ? req_a : 32'hFFFF_FFFF;
            end
            WAIT: begin
                if (div_available)    raw_q <= div_c;
                else if (timeout_hit) raw_q <= '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer with a behavioural unsigned divider model.
module tb_div_sequencer;

    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 96;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, req_valid, req_signed, req_rem, rsp_ready;
    logic [31:0]      req_a, req_b;
    logic [TAG_W-1:0] req_tag;
    logic             req_ready, div_go, div_divs, div_remainder;
    logic [31:0]      div_a, div_b;
    logic [31:0]      div_c = '0;
    logic             div_available = 1'b0;
    logic             rsp_valid, rsp_zero, rsp_negative, rsp_err;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;

    div_sequencer #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .req_signed(req_signed), .req_rem(req_rem), .req_tag(req_tag),
        .div_a(div_a), .div_b(div_b), .div_go(div_go), .div_divs(div_divs),
        .div_remainder(div_remainder), .div_c(div_c), .div_available(div_available),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .rsp_zero(rsp_zero), .rsp_negative(rsp_negative), .rsp_err(rsp_err)
    );

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0, n_errors = 0;
    int   cyc = 0, acc_cyc = 0, last_lat = 0, pops = 0, go_count = 0;
    bit   rsp_seen = 0;
    int   div_delay = 5;
    bit   div_stub = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Divider stand-in: unsigned result of the magnitudes, available div_delay cycles after go.
    logic [31:0] m_a = '0, m_b = '0;
    logic        m_rem = 1'b0;
    int          m_cnt = 0;
    bit          m_busy = 0;
    always @(posedge clk) begin
        div_available <= 1'b0;
        if (div_go) begin
            m_a <= div_a; m_b <= div_b; m_rem <= div_remainder;
            m_cnt <= div_delay; m_busy <= 1'b1; go_count <= go_count + 1;
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                m_busy <= 1'b0;
                if (!div_stub) begin
                    div_available <= 1'b1;
                    div_c <= (m_b == 0) ? 32'd0 : (m_rem ? m_a % m_b : m_a / m_b);
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rsp_valid && !rsp_seen) begin
            rsp_seen = 1;
            last_lat = cyc - acc_cyc;
        end
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("rsp_data", rsp_data, e.data);
                check_eq("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
                check_eq("rsp_zero", 32'(rsp_zero), 32'(e.data == 32'd0));
                check_eq("rsp_negative", 32'(rsp_negative), 32'(e.data[31]));
            end
            pops++;
            rsp_seen = 0;
        end
    end

    function automatic exp_t expect_of(input logic [31:0] a, input logic [31:0] b,
                                       input logic s, input logic r, input logic [TAG_W-1:0] t);
        exp_t e;
        logic signed [31:0] sa, sbv, q, m;
        e.tag = t;
        e.err = 1'b0;
        sa  = $signed(a);
        sbv = $signed(b);
        if (b == 32'd0) begin
            e.err  = 1'b1;
            e.data = r ? a : 32'hFFFF_FFFF;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'sh8000_0000;
                m = 32'sd0;
            end else begin
                q = sa / sbv;
                m = sa % sbv;
            end
            e.data = r ? $unsigned(m) : $unsigned(q);
        end else begin
            e.data = r ? a % b : a / b;
        end
        return e;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic r, input logic [TAG_W-1:0] t, input bit tmo);
        int n = 0;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_a = a; req_b = b; req_signed = s; req_rem = r; req_tag = t;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) begin
            check_eq("accept_wait", 32'd0, 32'd1);
            req_valid = 1'b0;
        end else begin
            e = expect_of(a, b, s, r, t);
            if (tmo) begin e.data = '0; e.err = 1'b1; end
            sb.push_back(e);
            @(negedge clk);
            acc_cyc   = cyc;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(sb.size() == 0 && req_ready) && n < 400) begin @(negedge clk); n++; end
        check_eq("drain_in_time", 32'(n < 400), 32'd1);
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic r, input logic [TAG_W-1:0] t);
        send(a, b, s, r, t, 1'b0);
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, nv, n;
        logic [31:0] h_data, ra, rb;
        logic [TAG_W:0] h_misc;

        reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
        req_signed = 1'b0; req_rem = 1'b0; req_tag = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_div_go", 32'(div_go), 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("rst_rsp_data", rsp_data, 32'd0);
        check_eq("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        check_eq("rst_div_ab", div_a | div_b, 32'd0);
        check_eq("div_divs", 32'(div_divs), 32'd0);
        reset = 1'b0;

        // Unsigned quotient / remainder, latency 3 + divider cycles
        div_delay = 5;
        txn(32'd100, 32'd7, 1'b0, 1'b0, 4'h3);
        check_eq("lat_d5", 32'(last_lat), 32'd8);
        txn(32'd100, 32'd7, 1'b0, 1'b1, 4'hA);

        // Signed operands
        div_delay = 1;
        txn(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0, 4'h1);
        check_eq("lat_d1", 32'(last_lat), 32'd4);
        txn(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, 4'h2);
        div_delay = 33;
        txn(32'd100, 32'hFFFF_FFF9, 1'b1, 1'b0, 4'h4);
        txn(32'd100, 32'hFFFF_FFF9, 1'b1, 1'b1, 4'h5);

        // Divide by zero: no go, response one cycle after accept
        g0 = go_count;
        send(32'h1234, 32'd0, 1'b0, 1'b0, 4'h6, 1'b0);
        wait_done();
        check_eq("lat_div0", 32'(last_lat), 32'd1);
        txn(32'h1234, 32'd0, 1'b1, 1'b1, 4'h7);
        check_eq("div0_no_go", 32'(go_count), 32'(g0));

        // Signed overflow wraps
        div_delay = 3;
        txn(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'h8);
        txn(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'h9);

        // Backpressure: response held stable, no acceptance
        @(posedge clk); #2 rsp_ready = 1'b0;
        send(32'd1000, 32'd3, 1'b0, 1'b0, 4'hB, 1'b0);
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        check_eq("bp_valid_seen", 32'(rsp_valid), 32'd1);
        h_data = rsp_data;
        h_misc = {rsp_err, rsp_tag};
        repeat (10) begin
            @(negedge clk);
            check_eq("bp_hold_data", rsp_data, h_data);
            check_eq("bp_hold_ctl", 32'({req_ready, rsp_valid, rsp_err, rsp_tag}),
                     32'({1'b0, 1'b1, h_misc}));
        end
        @(posedge clk); #2 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("bp_idle_after", 32'({req_ready, rsp_valid}), 32'b10);
        txn(32'd7, 32'd2, 1'b0, 1'b1, 4'hC);

        // Divider never answers: timeout error
        div_stub = 1;
        send(32'd50, 32'd5, 1'b0, 1'b0, 4'hD, 1'b1);
        wait_done();
        check_eq("lat_timeout", 32'(last_lat), 32'(TIMEOUT + 2));
        div_stub = 0;

        // Reset while waiting; the late available pulse must be ignored
        div_delay = 20;
        send(32'd77, 32'd7, 1'b0, 1'b0, 4'hE, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        rsp_seen = 0;
        check_eq("midrst_idle", 32'({req_ready, rsp_valid}), 32'b10);
        nv = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid || !req_ready) nv++;
        end
        check_eq("stale_avail_ignored", 32'(nv), 32'd0);
        txn(32'd77, 32'd7, 1'b0, 1'b0, 4'hF);

        // Mixed random requests
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = (i == 4) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            div_delay = $urandom_range(1, 40);
            txn(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i));
        end

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
